nw_wavefront: RTL and testbench

//  Parametrised Needleman-Wunsch global-alignment scorer. It computes the full (LENGTH+1)^2 score

---
 rtl/nw_pkg.sv | 26 ++
 rtl/nw_wavefront_pe.sv | 48 ++++
 rtl/nw_wavefront.sv | 126 ++++++++++++
 tb/tb_nw_wavefront.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/nw_pkg.sv
// Shared FSM encodings and scoring helpers for the Needleman-Wunsch wavefront engine.
// Helpers work in 32-bit int so one package serves every score width up to 32 bits.
package nw_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Strict compares keep the first of equal candidates: diag, then up, then left.
    function automatic int max3(input int diag, input int up, input int left);
        int best;
        best = diag;
        if (up > best) best = up;
        if (left > best) best = left;
        return best;
    endfunction

    function automatic int boundary(input int idx, input int weight);
        return idx * weight;
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

endpackage

// File: rtl/nw_wavefront_pe.sv
// One scoring cell: registers H for its row and a one-diagonal-delayed copy that
// becomes the corner input of the next row's cell.
module nw_pe
    import nw_pkg::*;
#(
    parameter int CWIDTH   = 2,
    parameter int SWIDTH   = 16,
    parameter int MATCH    = 1,
    parameter int MISMATCH = -1,
    parameter int INDEL    = -1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_clr,
    input  logic                     i_en,
    input  logic [CWIDTH-1:0]        i_a,
    input  logic [CWIDTH-1:0]        i_b,
    input  logic signed [SWIDTH-1:0] i_up,
    input  logic signed [SWIDTH-1:0] i_corner,
    input  logic signed [SWIDTH-1:0] i_left,
    output logic signed [SWIDTH-1:0] o_h,
    output logic signed [SWIDTH-1:0] o_h_d
);

    logic signed [SWIDTH-1:0] r_h;
    logic signed [SWIDTH-1:0] r_h_d;
    int                       w_best;

    always_comb begin
        w_best = max3(int'(i_corner) + ((i_a == i_b) ? MATCH : MISMATCH),
                      int'(i_up) + INDEL,
                      int'(i_left) + INDEL);
    end

    always_ff @(posedge clk) begin
        if (!rst_n || i_clr) begin
            r_h   <= '0;
            r_h_d <= '0;
        end else if (i_en) begin
            r_h   <= SWIDTH'(w_best);
            r_h_d <= r_h;
        end
    end

    assign o_h   = r_h;
    assign o_h_d = r_h_d;

endmodule

// File: rtl/nw_wavefront.sv
// Systolic Needleman-Wunsch scorer: LENGTH cells sweep one anti-diagonal per clock.
// Cell i computes H[i][d-i]; the top injects boundary values and selects s2 characters.
module nw_wavefront
    import nw_pkg::*;
#(
    parameter int LENGTH   = 10,
    parameter int CWIDTH   = 2,
    parameter int SWIDTH   = 16,
    parameter int MATCH    = 1,
    parameter int MISMATCH = -1,
    parameter int INDEL    = -1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       valid,
    output logic                       ready,
    input  logic [LENGTH*CWIDTH-1:0]   s1,
    input  logic [LENGTH*CWIDTH-1:0]   s2,
    output logic signed [SWIDTH-1:0]   score,
    output logic                       done
);

    localparam int DW   = $clog2(2*LENGTH + 1);
    localparam int MAXW = max3(iabs(MATCH), iabs(MISMATCH), iabs(INDEL));

    if (SWIDTH < $clog2(2*LENGTH*MAXW + 1) + 1 || SWIDTH > 32) begin : g_width_check
        $error("nw_wavefront: SWIDTH too small for LENGTH and weights");
    end

    logic [1:0]                r_state;
    logic [DW-1:0]             r_d;
    logic [LENGTH*CWIDTH-1:0]  r_s1;
    logic [LENGTH*CWIDTH-1:0]  r_s2;
    logic signed [SWIDTH-1:0]  r_score;
    logic                      w_clr;
    logic signed [SWIDTH-1:0]  w_h  [1:LENGTH];
    logic signed [SWIDTH-1:0]  w_hd [1:LENGTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_d     <= '0;
            r_s1    <= '0;
            r_s2    <= '0;
            r_score <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_d <= DW'(2);
                    if (valid) begin
                        r_s1    <= s1;
                        r_s2    <= s2;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_d <= r_d + DW'(1);
                    if (r_d == DW'(2*LENGTH)) r_state <= ST_DONE;
                end
                ST_DONE: begin
                    r_score <= w_h[LENGTH];
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign w_clr = (r_state == ST_IDLE);
    assign ready = (r_state == ST_IDLE);
    assign done  = (r_state == ST_DONE);
    // The last cell already holds H[L][L] during DONE; the register keeps it afterwards.
    assign score = (r_state == ST_DONE) ? w_h[LENGTH] : r_score;

    for (genvar gi = 1; gi <= LENGTH; gi++) begin : g_pe
        int                       w_j;
        logic                     w_en;
        logic [CWIDTH-1:0]        w_b;
        logic signed [SWIDTH-1:0] w_up_src;
        logic signed [SWIDTH-1:0] w_cor_src;
        logic signed [SWIDTH-1:0] w_corner;
        logic signed [SWIDTH-1:0] w_left;

        if (gi == 1) begin : g_edge
            always_comb begin
                w_up_src  = SWIDTH'(boundary(w_j, INDEL));
                w_cor_src = SWIDTH'(boundary(w_j - 1, INDEL));
            end
        end else begin : g_chain
            assign w_up_src  = w_h[gi-1];
            assign w_cor_src = w_hd[gi-1];
        end

        always_comb begin
            w_j  = int'(r_d) - gi;
            w_en = (r_state == ST_RUN) && (w_j >= 1) && (w_j <= LENGTH);
            w_b  = '0;
            for (int k = 0; k < LENGTH; k++) begin
                if (w_j - 1 == k) w_b = r_s2[k*CWIDTH +: CWIDTH];
            end
            w_corner = (w_j == 1) ? SWIDTH'(boundary(gi - 1, INDEL)) : w_cor_src;
            w_left   = (w_j == 1) ? SWIDTH'(boundary(gi, INDEL)) : w_h[gi];
        end

        nw_pe #(
            .CWIDTH  (CWIDTH),
            .SWIDTH  (SWIDTH),
            .MATCH   (MATCH),
            .MISMATCH(MISMATCH),
            .INDEL   (INDEL)
        ) u_pe (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_clr   (w_clr),
            .i_en    (w_en),
            .i_a     (r_s1[(gi-1)*CWIDTH +: CWIDTH]),
            .i_b     (w_b),
            .i_up    (w_up_src),
            .i_corner(w_corner),
            .i_left  (w_left),
            .o_h     (w_h[gi]),
            .o_h_d   (w_hd[gi])
        );
    end

endmodule

// File: tb/tb_nw_wavefront.sv
// Scoreboard bench for nw_wavefront at LENGTH=4 with three weight sets; expected
// scores come from a plain dynamic-programming model and are compared on done.
module tb_nw_wavefront;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              valid0 = 1'b0, validx = 1'b0;
    logic [7:0]        s1_0 = '0, s2_0 = '0, s1_x = '0, s2_x = '0;
    logic              ready0, ready1, ready2, done0, done1, done2;
    logic signed [15:0] sc0, sc1, sc2;

    int n_chk = 0, n_pass = 0, cyc = 0;
    int q0[$], q1[$], q2[$];
    logic pd0 = 1'b0, pd1 = 1'b0, pd2 = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    nw_wavefront #(.LENGTH(4), .CWIDTH(2), .SWIDTH(16), .MATCH(1), .MISMATCH(-1), .INDEL(-1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .valid(valid0), .ready(ready0),
        .s1(s1_0), .s2(s2_0), .score(sc0), .done(done0));
    nw_wavefront #(.LENGTH(4), .CWIDTH(2), .SWIDTH(16), .MATCH(2), .MISMATCH(-1), .INDEL(-2)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .valid(validx), .ready(ready1),
        .s1(s1_x), .s2(s2_x), .score(sc1), .done(done1));
    nw_wavefront #(.LENGTH(4), .CWIDTH(2), .SWIDTH(16), .MATCH(3), .MISMATCH(-2), .INDEL(-1)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .valid(validx), .ready(ready2),
        .s1(s1_x), .s2(s2_x), .score(sc2), .done(done2));

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    endtask

    function automatic int nw_model(input logic [7:0] a, input logic [7:0] b,
                                    input int m, input int mm, input int ind);
        int h[5][5];
        int best;
        for (int i = 0; i <= 4; i++) begin
            h[i][0] = i * ind;
            h[0][i] = i * ind;
        end
        for (int i = 1; i <= 4; i++) begin
            for (int j = 1; j <= 4; j++) begin
                best = h[i-1][j-1] + ((a[2*(i-1) +: 2] == b[2*(j-1) +: 2]) ? m : mm);
                if (h[i-1][j] + ind > best) best = h[i-1][j] + ind;
                if (h[i][j-1] + ind > best) best = h[i][j-1] + ind;
                h[i][j] = best;
            end
        end
        return h[4][4];
    endfunction

    // Scoreboard pops on every done and confirms done is gone one cycle later.
    always @(negedge clk) begin
        if (pd0) chk("done0_width", int'(done0), 0);
        if (pd1) chk("done1_width", int'(done1), 0);
        if (pd2) chk("done2_width", int'(done2), 0);
        if (done0) begin
            if (q0.size() == 0) chk("dut0_unexpected_done", 1, 0);
            else chk("dut0_score", int'(sc0), q0.pop_front());
        end
        if (done1) begin
            if (q1.size() == 0) chk("dut1_unexpected_done", 1, 0);
            else chk("dut1_score", int'(sc1), q1.pop_front());
        end
        if (done2) begin
            if (q2.size() == 0) chk("dut2_unexpected_done", 1, 0);
            else chk("dut2_score", int'(sc2), q2.pop_front());
        end
        pd0 <= done0;
        pd1 <= done1;
        pd2 <= done2;
    end

    task automatic wait_ready0(input string tag);
        int n = 0;
        while (!ready0 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 40) chk(tag, n, 0);
    endtask

    task automatic run_job(input logic [7:0] a, input logic [7:0] b, input int exp0, input bit all);
        int n;
        wait_ready0("ready_timeout");
        s1_0 = a; s2_0 = b; valid0 = 1'b1;
        q0.push_back(exp0);
        if (all) begin
            s1_x = a; s2_x = b; validx = 1'b1;
            q1.push_back(nw_model(a, b, 2, -1, -2));
            q2.push_back(nw_model(a, b, 3, -2, -1));
        end
        @(posedge clk); #1;
        valid0 = 1'b0; validx = 1'b0;
        chk("ready_drop", int'(ready0), 0);
        n = 0;
        while (!done0 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("latency", n, 7);
        @(posedge clk); #1;
        chk("ready_back", int'(ready0), 1);
    endtask

    initial begin
        int last, n;
        logic [7:0] pa, pb;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", int'(ready0), 1);
        chk("rst_done", int'(done0), 0);
        chk("rst_score", int'(sc0), 0);
        rst_n = 1'b1;

        run_job(8'h00, 8'h00, 4, 1'b0);
        run_job(8'h00, 8'h55, -4, 1'b0);
        run_job(8'hE4, 8'h39, 1, 1'b0);

        // valid held high: strings are swapped to garbage while the engine is busy
        last = 0;
        valid0 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_ready0("t4_ready_timeout");
            pa = k[0] ? 8'hE4 : 8'h1B;
            pb = k[0] ? 8'h39 : 8'hB1;
            s1_0 = pa; s2_0 = pb;
            q0.push_back(nw_model(pa, pb, 1, -1, -1));
            if (k > 0) chk("t4_period", cyc - last, 9);
            last = cyc;
            @(posedge clk); #1;
            s1_0 = ~pa; s2_0 = ~pb;
            if (k == 3) valid0 = 1'b0;
        end
        n = 0;
        while (q0.size() != 0 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("t4_drained", q0.size(), 0);

        // reset while the wavefront is at d=5
        wait_ready0("t5_ready_timeout");
        s1_0 = 8'hE4; s2_0 = 8'h39; valid0 = 1'b1;
        @(posedge clk); #1;
        valid0 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("t5_ready", int'(ready0), 1);
        chk("t5_done", int'(done0), 0);
        chk("t5_score", int'(sc0), 0);
        n = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (done0) n++;
        end
        chk("t5_no_done", n, 0);
        run_job(8'hE4, 8'h39, 1, 1'b0);

        for (int k = 0; k < 10; k++) begin
            pa = 8'($urandom_range(0, 255));
            pb = 8'($urandom_range(0, 255));
            run_job(pa, pb, nw_model(pa, pb, 1, -1, -1), 1'b1);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("q0_empty", q0.size(), 0);
        chk("q1_empty", q1.size(), 0);
        chk("q2_empty", q2.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
